hub75_row_driver: RTL and testbench
===================================

HUB75_ROW_DRIVER -- requirements
Module: hub75_row_driver

Interface
REQ-001 The module SHALL have parameter NUM_COLS, default 64: pixels shifted per row.
REQ-002 The module SHALL have parameter NUM_ROWS, default 32: panel rows, giving NUM_ROWS/2 scan addresses.
REQ-003 The module SHALL have parameter CLK_DIV, default 2: clk cycles per bclk half-period, >=1.
REQ-004 The module SHALL have parameter ON_CYCLES, default 256: clk cycles oe_out is held low per row.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port enable, input, 1 bit: run scan while high.
REQ-008 The module SHALL have port rd_addr, output, log2(NUM_ROWS/2)+log2(NUM_COLS) bits: frame memory address {row, col}.
REQ-009 The module SHALL have port rd_data, input, 6 bits: {rgb_top[2:0], rgb_bot[2:0]}, valid one cycle after rd_addr.
REQ-010 The module SHALL have port bclk, output, 1 bit: shift clock; the panel samples on its rising edge.
REQ-011 The module SHALL have ports rgb_top and rgb_bot, outputs, 3 bits each: serial colour data.
REQ-012 The module SHALL have port addr_out, output, 4 bits: row-pair address.
REQ-013 The module SHALL have port oe_out, output, 1 bit: output enable, active-low (1 = blank).
REQ-014 The module SHALL have port le_out, output, 1 bit: latch enable, active-high.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY and NEXT.
REQ-016 In IDLE with enable=1, the FSM SHALL go to LOAD with the row counter at 0.
REQ-017 LOAD SHALL last 1 cycle, issue rd_addr={row,0}, and go to SHIFT_LO.
REQ-018 SHIFT_LO SHALL last CLK_DIV cycles with bclk=0, and rgb_top/rgb_bot SHALL be registered from rd_data on its first cycle.
REQ-019 SHIFT_HI SHALL last CLK_DIV cycles with bclk=1, holding rgb stable.
REQ-020 SHIFT_HI SHALL issue rd_addr for column c+1 on its last cycle, except after the last column.
REQ-021 Column 0 SHALL be shifted first and column NUM_COLS-1 last; after NUM_COLS columns the FSM SHALL go to BLANK.
REQ-022 BLANK SHALL last 1 cycle with bclk=0 and oe_out=1.
REQ-023 LATCH SHALL last CLK_DIV cycles with le_out=1, and addr_out SHALL take the row counter on its first cycle.
REQ-024 DISPLAY SHALL last ON_CYCLES cycles with oe_out=0 and le_out=0.
REQ-025 NEXT SHALL last 1 cycle with oe_out=1, and increment the row counter modulo NUM_ROWS/2 (15 wraps to 0).
REQ-026 From NEXT the FSM SHALL go to LOAD if enable=1, otherwise to IDLE.
REQ-027 oe_out SHALL be 1 in every state except DISPLAY.
REQ-028 le_out SHALL be 1 only in LATCH.
REQ-029 If enable falls mid-row, the current row SHALL complete through NEXT and the FSM SHALL then idle.
REQ-030 Row time SHALL be 3 + 2*CLK_DIV*NUM_COLS + CLK_DIV + ON_CYCLES cycles.
REQ-031 Half-period and ON counters SHALL be sized from the parameters, with no truncation.

Reset
REQ-032 While reset=1, the FSM SHALL be IDLE with bclk=0, rgb_top=0, rgb_bot=0, addr_out=0, oe_out=1, le_out=0, rd_addr=0, and row and column counters 0.
REQ-033 reset SHALL override enable; a reset mid-row SHALL abort immediately, with outputs at reset values on the next edge.

Configuration
REQ-034 With HUB75_FRAME_PULSE_EN defined, the module SHALL have output frame_done, pulsing 1 cycle in NEXT when the row counter is NUM_ROWS/2-1, and 0 in reset.
REQ-035 Without HUB75_FRAME_PULSE_EN, the frame_done port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-036 Package hub75_pkg SHALL hold the FSM state enum, the pixel struct {top[2:0], bot[2:0]} and the HUB75_ADDR_W=4 constant.
REQ-037 Sub-module hub75_bclk_gen SHALL hold the CLK_DIV phase counter and emit phase_end strobes.

Verification
REQ-038 NUM_COLS=4, CLK_DIV=1, ON_CYCLES=8, memory row0 cols 0..3 = 6'h3F, 6'h00, 6'h2A, 6'h15, enable=1 -> 4 bclk rising edges with rgb {top,bot} 3F, 00, 2A, 15 at the edges; le_out high 1 cycle, then oe_out low for exactly 8 cycles; addr_out=0.
REQ-039 Same setup, 16 rows -> addr_out sequence 0..15 then 0; each row lasts 20 cycles.
REQ-040 enable dropped during SHIFT_HI of column 2 -> row completes, including 8 DISPLAY cycles, then IDLE with oe_out=1 and no further bclk edges.
REQ-041 reset asserted during DISPLAY -> next cycle oe_out=1, bclk=0, addr_out=0; re-enable restarts at row 0.
REQ-042 CLK_DIV=3 -> bclk high 3 cycles and low 3 cycles, and rgb never changes while bclk=1.
REQ-043 With HUB75_FRAME_PULSE_EN defined -> frame_done is a single-cycle pulse every 16*20 cycles, first at the end of row 15.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 row scan driver.
package hub75_pkg;

    localparam int unsigned HUB75_ADDR_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY,
        NEXT
    } hub75_state_e;

    typedef struct packed {
        logic [2:0] top;
        logic [2:0] bot;
    } hub75_pixel_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_bclk_gen.sv
// Phase counter for bclk half-periods and latch pulses; each phase lasts CLK_DIV cycles
// and restarts whenever run drops.
module hub75_bclk_gen
    import hub75_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic phase_start_c,
    output logic phase_pre_end_c,
    output logic phase_end_c
);

    localparam int unsigned CNT_W   = cnt_width(CLK_DIV);
    localparam int unsigned PRE_IDX = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

    logic [CNT_W-1:0] phase_cnt;

    always_ff @(posedge clk) begin
        if (reset || !run || phase_end_c) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
        end
    end

    // Pre-end marks the cycle before the last one, so a fetch can be issued on the last cycle.
    assign phase_start_c   = run && (phase_cnt == '0);
    assign phase_end_c     = run && (phase_cnt == CNT_W'(CLK_DIV - 1));
    assign phase_pre_end_c = run && (CLK_DIV > 1) && (phase_cnt == CNT_W'(PRE_IDX));

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 panel row scanner: fetches a row from frame memory, shifts it out on bclk,
// latches it and displays it for ON_CYCLES. Define HUB75_FRAME_PULSE_EN for frame_done.
module hub75_row_driver
    import hub75_pkg::*;
#(
    parameter int unsigned NUM_COLS  = 64,
    parameter int unsigned NUM_ROWS  = 32,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ON_CYCLES = 256
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic                                                     enable,
    output logic [cnt_width(NUM_ROWS/2)+cnt_width(NUM_COLS)-1:0]     rd_addr,
    input  logic [5:0]                                               rd_data,
    output logic                                                     bclk,
    output logic [2:0]                                               rgb_top,
    output logic [2:0]                                               rgb_bot,
    output logic [HUB75_ADDR_W-1:0]                                  addr_out,
    output logic                                                     oe_out,
    output logic                                                     le_out
`ifdef HUB75_FRAME_PULSE_EN
    ,
    output logic                                                     frame_done
`endif
);

    localparam int unsigned ROW_PAIRS = NUM_ROWS / 2;
    localparam int unsigned ROW_W     = cnt_width(ROW_PAIRS);
    localparam int unsigned COL_W     = cnt_width(NUM_COLS);
    localparam int unsigned ON_W      = cnt_width(ON_CYCLES);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_PAIRS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);

    hub75_state_e     state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ON_W-1:0]  on_cnt;

    hub75_pixel_t     rd_pix_c;
    logic [ROW_W-1:0] next_row_c;
    logic             phase_run_c;
    logic             phase_start_c;
    logic             phase_pre_end_c;
    logic             phase_end_c;
    logic             addr_step_c;

    assign rd_pix_c    = hub75_pixel_t'(rd_data);
    assign next_row_c  = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    assign phase_run_c = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH);

    // Next-column fetch lands on the last bclk-high cycle; with CLK_DIV=1 that cycle is entered
    // straight from SHIFT_LO, so the address must be registered there instead.
    assign addr_step_c = (col != COL_LAST) &&
                         (((state == SHIFT_HI) && phase_pre_end_c) ||
                          ((CLK_DIV == 1) && (state == SHIFT_LO) && phase_end_c));

    hub75_bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_gen (
        .clk            (clk),
        .reset          (reset),
        .run            (phase_run_c),
        .phase_start_c  (phase_start_c),
        .phase_pre_end_c(phase_pre_end_c),
        .phase_end_c    (phase_end_c)
    );

    // Scan FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            on_cnt   <= '0;
            rd_addr  <= '0;
            bclk     <= 1'b0;
            rgb_top  <= '0;
            rgb_bot  <= '0;
            addr_out <= '0;
            oe_out   <= 1'b1;
            le_out   <= 1'b0;
`ifdef HUB75_FRAME_PULSE_EN
            frame_done <= 1'b0;
`endif
        end else begin
`ifdef HUB75_FRAME_PULSE_EN
            frame_done <= 1'b0;
`endif
            if (addr_step_c) begin
                rd_addr <= {row, col + COL_W'(1)};
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        row     <= '0;
                        col     <= '0;
                        rd_addr <= '0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    state <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (phase_start_c) begin
                        rgb_top <= rd_pix_c.top;
                        rgb_bot <= rd_pix_c.bot;
                    end
                    if (phase_end_c) begin
                        bclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end_c) begin
                        bclk <= 1'b0;
                        if (col == COL_LAST) begin
                            state <= BLANK;
                        end else begin
                            col   <= col + COL_W'(1);
                            state <= SHIFT_LO;
                        end
                    end
                end
                BLANK: begin
                    addr_out <= HUB75_ADDR_W'(row);
                    le_out   <= 1'b1;
                    state    <= LATCH;
                end
                LATCH: begin
                    if (phase_end_c) begin
                        le_out <= 1'b0;
                        oe_out <= 1'b0;
                        on_cnt <= '0;
                        state  <= DISPLAY;
                    end
                end
                DISPLAY: begin
                    if (on_cnt == ON_LAST) begin
                        oe_out <= 1'b1;
                        state  <= NEXT;
`ifdef HUB75_FRAME_PULSE_EN
                        frame_done <= (row == ROW_LAST);
`endif
                    end else begin
                        on_cnt <= on_cnt + ON_W'(1);
                    end
                end
                NEXT: begin
                    row <= next_row_c;
                    col <= '0;
                    if (enable) begin
                        rd_addr <= {next_row_c, COL_W'(0)};
                        state   <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_row_driver.sv
// Bench for hub75_row_driver: two lanes (CLK_DIV=1 and CLK_DIV=3), each with its own memory,
// expected-output queues and monitor.
module tb_hub75_row_driver;

    localparam int unsigned NC  = 4;
    localparam int unsigned NR2 = 16;
    localparam int unsigned ON  = 8;

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   lanes_done = 0;

    always #5 clk = ~clk;

    task automatic check(input int lane, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL L%0d %s: got %0d expected %0d", lane, name, act, exp);
        end
    endtask

    task automatic fail_now(input int lane, input string name);
        checks++;
        failures++;
        $display("FAIL L%0d %s: output seen but nothing was expected", lane, name);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned CD = (g == 0) ? 1 : 3;
        localparam int ROW_T   = 3 + 2 * int'(CD) * int'(NC) + int'(CD) + int'(ON);
        localparam int FRAME_T = int'(NR2) * ROW_T;

        logic       reset = 1'b1;
        logic       enable = 1'b0;
        logic [5:0] rd_addr;
        logic [5:0] rd_data = 6'd0;
        logic [5:0] mem [NR2*NC];
        logic       bclk;
        logic [2:0] rgb_top;
        logic [2:0] rgb_bot;
        logic [3:0] addr_out;
        logic       oe_out;
        logic       le_out;
`ifdef HUB75_FRAME_PULSE_EN
        logic       frame_done;
`endif

        hub75_row_driver #(
            .NUM_COLS (NC),
            .NUM_ROWS (2 * NR2),
            .CLK_DIV  (CD),
            .ON_CYCLES(ON)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .rd_addr (rd_addr),
            .rd_data (rd_data),
            .bclk    (bclk),
            .rgb_top (rgb_top),
            .rgb_bot (rgb_bot),
            .addr_out(addr_out),
            .oe_out  (oe_out),
            .le_out  (le_out)
`ifdef HUB75_FRAME_PULSE_EN
            ,
            .frame_done(frame_done)
`endif
        );

        // Frame memory with one cycle read latency.
        always @(posedge clk) rd_data <= mem[rd_addr];

        logic [5:0] q_pix [$];
        int         q_row [$];
        bit         run_cont = 1'b0;
        int         n_rise = 0, n_latch = 0, n_fd = 0, cyc = 0;
        int         hi_len = 0, lo_len = 0, le_len = 0, oe_len = 0;
        int         last_le_cyc = 0, last_fd_cyc = 0, last_exp_row = -1;
        bit         have_le = 1'b0, have_fd = 1'b0;
        logic       p_bclk = 1'b0, p_le = 1'b0, p_oe = 1'b1, p_fd = 1'b0;
        logic [5:0] p_pix = 6'd0;
        logic [5:0] pix;

        // Monitor: samples on the falling clock edge and pops expectations on each event.
        initial forever begin
            @(negedge clk);
            cyc++;
            pix = {rgb_top, rgb_bot};
            if (reset) begin
                p_bclk = 1'b0; p_le = 1'b0; p_oe = 1'b1; p_fd = 1'b0;
                hi_len = 0; lo_len = 0; le_len = 0; oe_len = 0;
                have_le = 1'b0; have_fd = 1'b0;
            end else begin
                if (bclk && !p_bclk) begin
                    if ((n_rise % int'(NC)) != 0) check(g, "bclk_low", lo_len, int'(CD));
                    n_rise++;
                    if (q_pix.size() == 0) fail_now(g, "pixel_extra");
                    else check(g, "pixel", pix, q_pix.pop_front());
                    hi_len = 0;
                end
                if (!bclk && p_bclk) begin
                    check(g, "bclk_high", hi_len, int'(CD));
                    lo_len = 0;
                end
                if (bclk && p_bclk) check(g, "rgb_hold", pix, p_pix);
                if (bclk) begin
                    hi_len++;
                    check(g, "oe_in_shift", oe_out, 1);
                end else begin
                    lo_len++;
                end

                if (le_out && !p_le) begin
                    n_latch++;
                    if (q_row.size() == 0) fail_now(g, "latch_extra");
                    else begin
                        last_exp_row = q_row.pop_front();
                        check(g, "addr_out", addr_out, last_exp_row);
                    end
                    if (have_le && run_cont) check(g, "row_period", cyc - last_le_cyc, ROW_T);
                    have_le = 1'b1;
                    last_le_cyc = cyc;
                    le_len = 0;
                end
                if (!le_out && p_le) check(g, "le_width", le_len, int'(CD));
                if (le_out) begin
                    le_len++;
                    check(g, "oe_in_latch", oe_out, 1);
                end

                if (!oe_out && p_oe) check(g, "latch_before_on", p_le, 1);
                if (oe_out && !p_oe) check(g, "on_time", oe_len, int'(ON));
                if (!oe_out) oe_len++;
                else oe_len = 0;

`ifdef HUB75_FRAME_PULSE_EN
                if (frame_done) begin
                    check(g, "fd_single", p_fd, 0);
                    check(g, "fd_row", last_exp_row, int'(NR2) - 1);
                    if (have_fd) check(g, "fd_period", cyc - last_fd_cyc, FRAME_T);
                    have_fd = 1'b1;
                    last_fd_cyc = cyc;
                    n_fd++;
                end
                p_fd = frame_done;
`endif
                p_bclk = bclk;
                p_le   = le_out;
                p_oe   = oe_out;
                p_pix  = pix;
            end
        end

        task automatic tick(input int n);
            repeat (n) begin
                @(negedge clk);
                #1;
            end
        endtask

        // Expected output of a row: its NC pixels in column order, then a latch of its address.
        task automatic push_rows(input int start, input int count);
            for (int k = 0; k < count; k++) begin
                int r;
                r = (start + k) % int'(NR2);
                for (int c = 0; c < int'(NC); c++) q_pix.push_back(mem[r * int'(NC) + c]);
                q_row.push_back(r);
            end
        endtask

        task automatic fill_mem();
            for (int i = 0; i < int'(NR2 * NC); i++) mem[i] = 6'($urandom);
        endtask

        task automatic check_reset_outputs(input string tag);
            check(g, {tag, "_bclk"}, bclk, 0);
            check(g, {tag, "_rgb_top"}, rgb_top, 0);
            check(g, {tag, "_rgb_bot"}, rgb_bot, 0);
            check(g, {tag, "_addr_out"}, addr_out, 0);
            check(g, {tag, "_oe_out"}, oe_out, 1);
            check(g, {tag, "_le_out"}, le_out, 0);
            check(g, {tag, "_rd_addr"}, rd_addr, 0);
`ifdef HUB75_FRAME_PULSE_EN
            check(g, {tag, "_frame_done"}, frame_done, 0);
`endif
        endtask

        task automatic wait_latches(input int target, input string name);
            int k;
            k = 0;
            while (n_latch < target && k < 4000) begin
                tick(1);
                k++;
            end
            check(g, name, n_latch, target);
        endtask

        task automatic wait_rises(input int target, input string name);
            int k;
            k = 0;
            while (n_rise < target && k < 4000) begin
                tick(1);
                k++;
            end
            check(g, name, n_rise, target);
        endtask

        task automatic wait_display(input string name);
            int k;
            k = 0;
            while (oe_out !== 1'b0 && k < 200) begin
                tick(1);
                k++;
            end
            check(g, name, oe_out, 0);
        endtask

        task automatic check_idle(input string tag);
            check(g, {tag, "_pix_left"}, q_pix.size(), 0);
            check(g, {tag, "_rows_left"}, q_row.size(), 0);
            check(g, {tag, "_oe_idle"}, oe_out, 1);
            check(g, {tag, "_bclk_idle"}, bclk, 0);
        endtask

        if (CD == 1) begin : g_full
            initial begin
                int rows_a;
                rows_a = 2 * int'(NR2) + 1;
                tick(3);
                check_reset_outputs("reset");
                fill_mem();
                mem[0] = 6'h3F; mem[1] = 6'h00; mem[2] = 6'h2A; mem[3] = 6'h15;
                push_rows(0, rows_a);
                run_cont = 1'b1;
                reset = 1'b0;
                enable = 1'b1;
                // Drop enable while column 2 of the last row is on bclk high.
                wait_rises((rows_a - 1) * int'(NC) + 3, "wait_drop_point");
                enable = 1'b0;
                tick(60);
                check(g, "rises_after_stop", n_rise, rows_a * int'(NC));
                check(g, "latches_after_stop", n_latch, rows_a);
                check_idle("stop");
`ifdef HUB75_FRAME_PULSE_EN
                check(g, "frame_pulses", n_fd, 2);
`endif
                run_cont = 1'b0;

                push_rows(0, 3);
                enable = 1'b1;
                wait_latches(rows_a + 3, "wait_row2_latch");
                wait_display("wait_row2_display");
                tick(3);
                reset = 1'b1;
                tick(1);
                check_reset_outputs("abort");
                enable = 1'b0;
                tick(1);
                reset = 1'b0;
                check(g, "abort_rows_left", q_row.size(), 0);

                push_rows(0, 2);
                enable = 1'b1;
                wait_latches(rows_a + 5, "wait_restart");
                enable = 1'b0;
                tick(60);
                check(g, "latches_final", n_latch, rows_a + 5);
                check_idle("final");
                lanes_done++;
            end
        end else begin : g_short
            initial begin
                tick(3);
                check_reset_outputs("reset");
                fill_mem();
                push_rows(0, 3);
                run_cont = 1'b1;
                reset = 1'b0;
                enable = 1'b1;
                wait_latches(3, "wait_row2_latch");
                enable = 1'b0;
                tick(150);
                check(g, "rises_final", n_rise, 3 * int'(NC));
                check_idle("final");
                lanes_done++;
            end
        end
    end

    initial begin
        int k;
        k = 0;
        while (lanes_done < 2 && k < 20000) begin
            @(posedge clk);
            k++;
        end
        check(-1, "lanes_finished", lanes_done, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
